ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
- Built-in self-test initiator that drives the single-port 32x8 RAM interface (address, data_in, write_enb, read_enb, data_out).
- On a start pulse it runs a three-element March sequence over every address: {W(P)} ascending, {R(P),W(~P)} ascending, {R(~P)} ascending.
- It compares every read, then reports done, pass, error count and the first failing address and data.
- It sits beside the RAM and owns the RAM's write and read strobes while busy.

Parameters:
- ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- PATTERN, 8'h55, background pattern P; the inverse pattern is ~PATTERN.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin test; sampled only when busy=0.
- ram_address  output  ADDR_W  address to RAM.
- ram_data_in  output  DATA_W  write data to RAM.
- ram_write_enb  output  1  RAM write strobe.
- ram_read_enb  output  1  RAM read strobe.
- ram_data_out  input  DATA_W  RAM read data, valid the cycle after the read strobe is captured.
- busy  output  1  high from the edge after start until DONE.
- done  output  1  level, high in DONE until the next start or reset.
- pass  output  1  valid when done=1; 1 when err_count==0.
- err_count  output  ADDR_W+2  number of miscompares (max 2*DEPTH; does not saturate).
- fail_addr  output  ADDR_W  address of the first miscompare.
- fail_data  output  DATA_W  read data of the first miscompare.

Behaviour:
- Reset: state=IDLE; all outputs 0, including both RAM strobes. Reset applied mid-test aborts the test at that edge and the RAM contents are left as-is.
- All outputs are registered. ram_write_enb and ram_read_enb are never both 1, because the RAM ignores that combination.
- States: IDLE -> W0 -> R0W1 -> R1 -> DRAIN -> DONE; DONE -> W0 on start.
- On start, err_count, fail_addr, fail_data, done and pass are cleared.
- IDLE/DONE: strobes 0; start=1 at edge E0 enters W0.
- W0: one address per cycle, addresses 0..DEPTH-1, write_enb=1, data_in=P. The last write is captured at E32. This state is DEPTH cycles long.
- R0W1: two cycles per address, addresses ascending.
  - Cycle a: read_enb=1.
  - Cycle b: write_enb=1, data_in=~P, and ram_data_out is compared against P in the same cycle.
  - This state is 2*DEPTH cycles long and occupies E32..E96.
- R1: one read issued per cycle, addresses 0..DEPTH-1, pipelined.
  - Data for a read issued in cycle k is compared against ~P in cycle k+1, using a registered pending flag and a registered address.
  - This state occupies E96..E128.
- DRAIN: one cycle with strobes 0; the last R1 compare happens here.
- DONE: entered at E129, where done=1, busy=0 and pass=(err_count==0).
- Compare is exact, 4-state: any x/z bit in ram_data_out counts as a mismatch.
- On a mismatch, err_count is incremented.
  - If it is the first mismatch since start, fail_addr and fail_data are captured.
  - Later mismatches do not overwrite fail_addr or fail_data.
- The address counter wraps from DEPTH-1 to 0 at each element boundary. No address is skipped or repeated.
- start while busy=1 is ignored. start and reset in the same cycle: reset wins.

Test Plan:
- Fault-free RAM, start at E0:
  - ram_write_enb high for exactly 64 cycles and ram_read_enb for exactly 64 cycles.
  - Addresses ascend 0..31 in each element.
  - done=1 and pass=1 from E129, with err_count=0.
- RAM model with bit0 of address 5 stuck at 1:
  - W(55) and R(55) are clean.
  - W(AA) stores AB, then R1 reads AB.
  - Result: done, pass=0, err_count=1, fail_addr=5, fail_data=8'hAB.
- Address 3 and address 9 both forced to 8'h00:
  - R0 miscompares at address 3 and address 9; R1 miscompares at address 3 and address 9.
  - Result: err_count=4, fail_addr=3, fail_data=8'h00.
- Assert reset at the edge that starts cycle 50 (inside R0W1):
  - From that edge, both strobes=0, busy=0, done=0, err_count=0.
  - A following start on a good RAM gives pass=1 at 129 edges after that start.
- Pulse start again at cycle 60 while busy: no restart, and done still occurs at E129. Then start from DONE clears done the next edge and reruns.
- PATTERN=8'h0F: writes carry 0F in W0 and F0 in R0W1; a good RAM gives pass=1. Throughout every run, assert that write_enb and read_enb are never both high.

Source files
------------

// File: rtl/ram_bist_ctrl_if.sv
// ram_bist_ctrl_if -- single-port RAM bus between the BIST controller and the RAM.
//   ram_address   : address to RAM
//   ram_data_in   : write data to RAM
//   ram_write_enb : write strobe
//   ram_read_enb  : read strobe
//   ram_data_out  : read data, valid the cycle after the read strobe is captured
// master = BIST controller, slave = RAM.
interface ram_bist_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_write_enb;
  logic              ram_read_enb;
  logic [DATA_W-1:0] ram_data_out;

  modport master (
    output ram_address, ram_data_in, ram_write_enb, ram_read_enb,
    input  ram_data_out
  );

  modport slave (
    input  ram_address, ram_data_in, ram_write_enb, ram_read_enb,
    output ram_data_out
  );
endinterface

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl -- March BIST initiator for a single-port RAM.
// Sequence after start: {W(P)} up, {R(P),W(~P)} up, {R(~P)} up, then DONE.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : begin a test (ignored while busy)
//   ram        : RAM bus (master side), all outputs registered
//   busy       : test in progress
//   done       : level, test finished (held until next start/reset)
//   pass       : valid with done, 1 when no miscompares
//   err_count  : number of miscompares
//   fail_addr  : address of first miscompare
//   fail_data  : read data of first miscompare
module ram_bist_ctrl #(
  parameter int                ADDR_W  = 5,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  ram_bist_ctrl_if.master     ram,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W+1:0]   err_count,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [DATA_W-1:0]   fail_data
);

  typedef enum logic [2:0] {IDLE, W0, R0W1, R1, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic              ph, ph_n;       // R0W1 sub-cycle: 0 = read, 1 = write
  logic              go;
  logic              we_n, re_n;
  logic [DATA_W-1:0] din_n;

  // A read strobe seen on the bus is checked one cycle later, when its data
  // is valid; address and expected value travel with it.
  logic              chk_pend;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] chk_exp;
  logic              mism;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ph_n    = ph;
    go      = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        go      = 1'b1;
        state_n = W0;
        cnt_n   = '0;
        ph_n    = 1'b0;
      end
      W0: if (cnt == LAST) begin
        state_n = R0W1;
        cnt_n   = '0;
        ph_n    = 1'b0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      R0W1: if (!ph) begin
        ph_n = 1'b1;
      end else begin
        ph_n = 1'b0;
        if (cnt == LAST) begin
          state_n = R1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      R1: if (cnt == LAST) begin
        state_n = DRAIN;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      DRAIN:   state_n = DONE;
      default: state_n = IDLE;
    endcase

    // Bus outputs are registered from the state being entered, so the
    // strobe for address k is on the bus during the cycle after it is chosen.
    we_n  = 1'b0;
    re_n  = 1'b0;
    din_n = '0;
    case (state_n)
      W0: begin
        we_n  = 1'b1;
        din_n = PATTERN;
      end
      R0W1: if (ph_n) begin
        we_n  = 1'b1;
        din_n = ~PATTERN;
      end else begin
        re_n = 1'b1;
      end
      R1:      re_n = 1'b1;
      default: ;
    endcase

    // 4-state compare: x/z on the read data counts as a miscompare.
    mism = chk_pend && (ram.ram_data_out !== chk_exp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      ph                <= 1'b0;
      ram.ram_address   <= '0;
      ram.ram_data_in   <= '0;
      ram.ram_write_enb <= 1'b0;
      ram.ram_read_enb  <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      pass              <= 1'b0;
      err_count         <= '0;
      fail_addr         <= '0;
      fail_data         <= '0;
      chk_pend          <= 1'b0;
      chk_addr          <= '0;
      chk_exp           <= '0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      ph                <= ph_n;
      ram.ram_address   <= cnt_n;
      ram.ram_data_in   <= din_n;
      ram.ram_write_enb <= we_n;
      ram.ram_read_enb  <= re_n;
      busy              <= (state_n == W0) || (state_n == R0W1) ||
                           (state_n == R1) || (state_n == DRAIN);
      done              <= (state_n == DONE);

      chk_pend <= ram.ram_read_enb;
      chk_addr <= ram.ram_address;
      chk_exp  <= (state == R1) ? ~PATTERN : PATTERN;

      if (go) begin
        err_count <= '0;
        fail_addr <= '0;
        fail_data <= '0;
        pass      <= 1'b0;
      end else if (mism) begin
        err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          fail_addr <= chk_addr;
          fail_data <= ram.ram_data_out;
        end
      end

      // Last R1 compare lands on the DRAIN->DONE edge, so fold it in here.
      if (state == DRAIN)
        pass <= (err_count == '0) && !mism;
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
module tb_ram_bist_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 32;
  localparam logic [7:0] P0 = 8'h55;
  localparam logic [7:0] P1 = 8'h0F;

  logic clk = 1'b0;
  logic reset, start, start1;
  logic busy, done, pass, busy1, done1, pass1;
  logic [AW+1:0] err_count, err_count1;
  logic [AW-1:0] fail_addr, fail_addr1;
  logic [DW-1:0] fail_data, fail_data1;

  int checks = 0;
  int failures = 0;
  int both_hi = 0;

  always #5 clk = ~clk;

  ram_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PATTERN(P0)) dut (
    .clk(clk), .reset(reset), .start(start), .ram(bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data));

  ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PATTERN(P1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ram(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .fail_addr(fail_addr1), .fail_data(fail_data1));

  // RAM model with per-address stuck-at-1 / stuck-at-0 bit masks on read.
  logic [7:0] mem [DEPTH];
  logic [7:0] mem1 [DEPTH];
  logic [7:0] sa1 [DEPTH];
  logic [7:0] sa0 [DEPTH];

  function automatic logic [7:0] rd(int a, logic [7:0] s);
    return (s | sa1[a]) & ~sa0[a];
  endfunction

  always @(posedge clk) begin
    if (bus.ram_write_enb) mem[bus.ram_address] <= bus.ram_data_in;
    if (bus.ram_read_enb) bus.ram_data_out <= rd(int'(bus.ram_address), mem[bus.ram_address]);
    if (bus1.ram_write_enb) mem1[bus1.ram_address] <= bus1.ram_data_in;
    if (bus1.ram_read_enb) bus1.ram_data_out <= mem1[bus1.ram_address];
  end

  always @(negedge clk) begin
    if (bus.ram_write_enb && bus.ram_read_enb) both_hi++;
    if (bus1.ram_write_enb && bus1.ram_read_enb) both_hi++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Expected bus activity i cycles after the start edge, straight from the
  // March element layout.
  typedef struct packed { logic we; logic re; logic [4:0] addr; logic [7:0] din; } op_t;

  function automatic op_t exp_op(int i, logic [7:0] p);
    op_t o;
    o = '0;
    if (i < 32) begin
      o.we = 1'b1; o.addr = 5'(i); o.din = p;
    end else if (i < 96) begin
      o.addr = 5'((i - 32) / 2);
      if ((i - 32) % 2 == 0) o.re = 1'b1;
      else begin o.we = 1'b1; o.din = ~p; end
    end else if (i < 128) begin
      o.re = 1'b1; o.addr = 5'(i - 96);
    end
    return o;
  endfunction

  function automatic logic op_ok(op_t e, logic we, logic re, logic [4:0] a, logic [7:0] d);
    if (we !== e.we || re !== e.re) return 1'b0;
    if ((we || re) && a !== e.addr) return 1'b0;
    if (we && d !== e.din) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: after W0 every cell holds P, after R0W1 every cell holds ~P;
  // each element reads every address once in ascending order.
  task automatic model(output logic [6:0] e, output logic [4:0] fa, output logic [7:0] fd);
    logic [7:0] v, x;
    e = '0; fa = '0; fd = '0;
    for (int el = 0; el < 2; el++) begin
      x = (el == 0) ? P0 : ~P0;
      for (int a = 0; a < DEPTH; a++) begin
        v = rd(a, x);
        if (v !== x) begin
          if (e == 0) begin fa = 5'(a); fd = v; end
          e++;
        end
      end
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin sa1[a] = '0; sa0[a] = '0; end
  endtask

  task automatic run0(input string nm, input int pulse_at, input logic [6:0] e_err,
                      input logic [4:0] e_fa, input logic [7:0] e_fd, input logic e_pass);
    int bad = 0, nwe = 0, nre = 0;
    @(negedge clk) start = 1'b1;
    for (int i = 0; i <= 129; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      if (!op_ok(exp_op(i, P0), bus.ram_write_enb, bus.ram_read_enb, bus.ram_address, bus.ram_data_in))
        bad++;
      if (bus.ram_write_enb) nwe++;
      if (bus.ram_read_enb) nre++;
      if (i == 0) begin
        chk({nm, "_busy0"}, 32'(busy), 32'd1);
        chk({nm, "_done_clr"}, 32'(done), 32'd0);
      end
      if (i == 128) chk({nm, "_done128"}, 32'(done), 32'd0);
    end
    start = 1'b0;
    chk({nm, "_ops"}, 32'(bad), 32'd0);
    chk({nm, "_nwe"}, 32'(nwe), 32'd64);
    chk({nm, "_nre"}, 32'(nre), 32'd64);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_pass"}, 32'(pass), 32'(e_pass));
    chk({nm, "_err"}, 32'(err_count), 32'(e_err));
    chk({nm, "_faddr"}, 32'(fail_addr), 32'(e_fa));
    chk({nm, "_fdata"}, 32'(fail_data), 32'(e_fd));
  endtask

  typedef struct {
    string      nm;
    int         pulse;
    int         a0; logic [7:0] s1_0; logic [7:0] s0_0;
    int         a1; logic [7:0] s1_1; logic [7:0] s0_1;
    logic [6:0] e_err; logic [4:0] e_fa; logic [7:0] e_fd; logic e_pass;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [6:0] me;
    logic [4:0] mfa;
    logic [7:0] mfd;
    int bad1;

    tbl[0] = '{"good",       -1, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00, 7'd0, 5'd0,  8'h00, 1'b1};
    tbl[1] = '{"sa1_a5",     -1,  5, 8'h01, 8'h00, -1, 8'h00, 8'h00, 7'd1, 5'd5,  8'hAB, 1'b0};
    tbl[2] = '{"zero_a3_a9", -1,  3, 8'h00, 8'hFF,  9, 8'h00, 8'hFF, 7'd4, 5'd3,  8'h00, 1'b0};
    tbl[3] = '{"sa0_a31",    -1, 31, 8'h00, 8'h01, -1, 8'h00, 8'h00, 7'd1, 5'd31, 8'h54, 1'b0};
    tbl[4] = '{"sa1_a0",     -1,  0, 8'h80, 8'h00, -1, 8'h00, 8'h00, 7'd1, 5'd0,  8'hD5, 1'b0};
    tbl[5] = '{"busy_start", 60, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00, 7'd0, 5'd0,  8'h00, 1'b1};

    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    clear_faults();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_faddr", 32'(fail_addr), 32'd0);
    chk("rst_fdata", 32'(fail_data), 32'd0);
    chk("rst_we", 32'(bus.ram_write_enb), 32'd0);
    chk("rst_re", 32'(bus.ram_read_enb), 32'd0);
    reset = 1'b0;

    foreach (tbl[k]) begin
      clear_faults();
      if (tbl[k].a0 >= 0) begin sa1[tbl[k].a0] = tbl[k].s1_0; sa0[tbl[k].a0] = tbl[k].s0_0; end
      if (tbl[k].a1 >= 0) begin sa1[tbl[k].a1] = tbl[k].s1_1; sa0[tbl[k].a1] = tbl[k].s0_1; end
      run0(tbl[k].nm, tbl[k].pulse, tbl[k].e_err, tbl[k].e_fa, tbl[k].e_fd, tbl[k].e_pass);
    end

    // Random stuck-at faults against the March-level reference.
    for (int r = 0; r < 8; r++) begin
      clear_faults();
      for (int n = $urandom_range(0, 3); n > 0; n--) begin
        int a;
        a = $urandom_range(0, DEPTH - 1);
        sa1[a] = 8'($urandom & $urandom);
        sa0[a] = 8'($urandom & $urandom & $urandom);
      end
      model(me, mfa, mfd);
      run0($sformatf("rnd%0d", r), -1, me, mfa, mfd, me == 0);
    end

    // Reset inside R0W1 with an error already recorded.
    clear_faults();
    sa0[3] = 8'hFF;
    @(negedge clk) start = 1'b1;
    for (int i = 0; i <= 49; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid_err_pre", 32'(err_count), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_we", 32'(bus.ram_write_enb), 32'd0);
    chk("mid_re", 32'(bus.ram_read_enb), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_err", 32'(err_count), 32'd0);
    reset = 1'b0;
    clear_faults();
    run0("after_rst", -1, 7'd0, 5'd0, 8'h00, 1'b1);

    // Second pattern on a good RAM.
    bad1 = 0;
    @(negedge clk) start1 = 1'b1;
    for (int i = 0; i <= 129; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (!op_ok(exp_op(i, P1), bus1.ram_write_enb, bus1.ram_read_enb, bus1.ram_address, bus1.ram_data_in))
        bad1++;
      if (i == 0) chk("p0f_w0_din", 32'(bus1.ram_data_in), 32'h0F);
      if (i == 33) chk("p0f_w1_din", 32'(bus1.ram_data_in), 32'hF0);
    end
    chk("p0f_ops", 32'(bad1), 32'd0);
    chk("p0f_done", 32'(done1), 32'd1);
    chk("p0f_pass", 32'(pass1), 32'd1);
    chk("p0f_err", 32'(err_count1), 32'd0);

    chk("strobes_exclusive", 32'(both_hi), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
